// File: rtl/led_key_ctrl.sv
// led_key_ctrl
//
// Multi-channel LED controller driven by debounced active-low push-buttons.
// Each debounced press advances its channel's mode OFF -> BLINK -> ON -> OFF.
// Channels share nothing but the clock and reset.
//
// Parameters:
//   CH            number of key/LED channels (1..16)
//   DEBOUNCE_CYC  consecutive differing samples needed to accept a level (>=2)
//   HALF_PERIOD   blink half-period in clk cycles (>=2)
//   LONG_CYC      long-press threshold in cycles from the press strobe (>=2)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n        raw keys, active-low, asynchronous to clk
//   led          LED drives, high = lit
//   mode         per-channel mode at [2i+1:2i]: 0 OFF, 1 BLINK, 2 ON
//   press_pulse  one-cycle strobe per accepted press
//   long_pulse   one-cycle strobe per long press
//
// Build option:
//   LED_CTRL_LONGPRESS_EN  when defined, holding a key for LONG_CYC cycles
//                          after its press strobe fires long_pulse and forces
//                          the channel to OFF. Otherwise long_pulse is 0.
//
// Mode FSM states:
//   state      | meaning
//   MODE_OFF   | LED dark, blink counter held at 0
//   MODE_BLINK | LED toggles every HALF_PERIOD cycles, starts lit
//   MODE_ON    | LED lit, blink counter held at 0
//   MODE_ILL   | unused encoding, returns to MODE_OFF next cycle

module led_key_ctrl #(
    parameter int CH           = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HALF_PERIOD  = 25_000_000,
    parameter int LONG_CYC     = 100_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   key_n,
    output logic [CH-1:0]   led,
    output logic [2*CH-1:0] mode,
    output logic [CH-1:0]   press_pulse,
    output logic [CH-1:0]   long_pulse
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_ON    = 2'd2,
        MODE_ILL   = 2'd3
    } mode_e;

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int BL_W = $clog2(HALF_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(HALF_PERIOD - 1);

`ifdef LED_CTRL_LONGPRESS_EN
    localparam int LG_W = $clog2(LONG_CYC + 1);
    localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_CYC - 1);
    localparam logic [LG_W-1:0] LONG_MAX  = LG_W'(LONG_CYC);
`else
    logic unused_long_cyc;
    assign unused_long_cyc = (LONG_CYC != 0);
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic            sync1_q;
        logic            sync2_q;
        logic            stable_q, stable_d;
        logic            stable_dly_q;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            press_q, press_d;
        logic            long_q, long_d;
        mode_e           mode_q, mode_d;
        logic            led_q, led_d;
        logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;

        // Debounce: count consecutive samples that disagree with the
        // accepted level; the DEBOUNCE_CYC-th one flips it.
        always_comb begin
            stable_d = stable_q;
            db_cnt_d = '0;
            if (sync2_q != stable_q) begin
                if (db_cnt_q == DB_LAST) begin
                    stable_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Strobe one cycle after the accepted level falls.
        assign press_d = stable_dly_q & ~stable_q;

`ifdef LED_CTRL_LONGPRESS_EN
        logic [LG_W-1:0] hold_q, hold_d;

        // Hold counter starts with the press strobe and saturates at
        // LONG_CYC, so a single hold yields a single long strobe.
        always_comb begin
            hold_d = hold_q;
            if (stable_q) begin
                hold_d = '0;
            end else if (press_q) begin
                hold_d = LG_W'(1);
            end else if ((hold_q != '0) && (hold_q != LONG_MAX)) begin
                hold_d = hold_q + LG_W'(1);
            end
        end

        assign long_d = !stable_q && (hold_q == LONG_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end
`else
        assign long_d = 1'b0;
`endif

        always_comb begin
            mode_d   = mode_q;
            led_d    = led_q;
            bl_cnt_d = bl_cnt_q;
            case (mode_q)
                MODE_OFF: begin
                    led_d    = 1'b0;
                    bl_cnt_d = '0;
                    if (press_q) begin
                        mode_d = MODE_BLINK;
                        led_d  = 1'b1;
                    end
                end
                MODE_BLINK: begin
                    // A press in the wrap cycle wins over the toggle.
                    if (press_q) begin
                        mode_d   = MODE_ON;
                        led_d    = 1'b1;
                        bl_cnt_d = '0;
                    end else if (bl_cnt_q == BL_LAST) begin
                        bl_cnt_d = '0;
                        led_d    = ~led_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + BL_W'(1);
                    end
                end
                MODE_ON: begin
                    led_d    = 1'b1;
                    bl_cnt_d = '0;
                    if (press_q) begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                    end
                end
                default: begin
                    mode_d   = MODE_OFF;
                    led_d    = 1'b0;
                    bl_cnt_d = '0;
                end
            endcase
            // Long press overrides whatever the short press selected.
            if (long_q) begin
                mode_d   = MODE_OFF;
                led_d    = 1'b0;
                bl_cnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q      <= 1'b1;
                sync2_q      <= 1'b1;
                stable_q     <= 1'b1;
                stable_dly_q <= 1'b1;
                db_cnt_q     <= '0;
                press_q      <= 1'b0;
                long_q       <= 1'b0;
                mode_q       <= MODE_OFF;
                led_q        <= 1'b0;
                bl_cnt_q     <= '0;
            end else begin
                sync1_q      <= key_n[i];
                sync2_q      <= sync1_q;
                stable_q     <= stable_d;
                stable_dly_q <= stable_q;
                db_cnt_q     <= db_cnt_d;
                press_q      <= press_d;
                long_q       <= long_d;
                mode_q       <= mode_d;
                led_q        <= led_d;
                bl_cnt_q     <= bl_cnt_d;
            end
        end

        assign led[i]           = led_q;
        assign mode[2*i +: 2]   = mode_q;
        assign press_pulse[i]   = press_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_led_key_ctrl.sv
// Bench for led_key_ctrl with CH=2, DEBOUNCE_CYC=4, HALF_PERIOD=8, LONG_CYC=32.
// A behavioural model tracks the outputs from the key history; a compare
// process checks it against the DUT every cycle out of reset, and directed
// literal expectations pin the timing of the model itself.

module tb_led_key_ctrl;
    localparam int CH  = 2;
    localparam int DEB = 4;
    localparam int HP  = 8;
    localparam int LC  = 32;
    localparam int WIN = DEB + 2;
`ifdef LED_CTRL_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   key_n = '1;
    logic [CH-1:0]   led;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   press_pulse;
    logic [CH-1:0]   long_pulse;

    led_key_ctrl #(
        .CH(CH), .DEBOUNCE_CYC(DEB), .HALF_PERIOD(HP), .LONG_CYC(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .led(led),
        .mode(mode), .press_pulse(press_pulse), .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait until the negedge following clock edge e.
    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // A level is accepted once DEB consecutive raw samples disagree with it;
    // the two synchroniser stages put that window 2..DEB+1 samples back.
    bit         win [CH][WIN];
    bit         m_stable [CH];
    bit         m_fell [CH];
    bit         m_press [CH];
    bit         m_long [CH];
    bit         pend [CH];
    int         pend_edge [CH];
    int         entry [CH];
    logic [1:0] m_mode [CH];
    bit         m_led [CH];
    int         n = 0;
    bit         all_diff, nxt_long;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < WIN; j++) win[c][j] = 1'b1;
                m_stable[c] = 1'b1; m_fell[c] = 1'b0; m_press[c] = 1'b0;
                m_long[c] = 1'b0; pend[c] = 1'b0; pend_edge[c] = 0;
                entry[c] = 0; m_mode[c] = 2'd0; m_led[c] = 1'b0;
            end
        end else begin
            n++;
            for (int c = 0; c < CH; c++) begin
                for (int j = WIN - 1; j > 0; j--) win[c][j] = win[c][j-1];
                win[c][0] = key_n[c];
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (win[c][j] == m_stable[c]) all_diff = 1'b0;

                nxt_long = 1'b0;
                if (LONG_EN) begin
                    if (pend[c] && m_stable[c]) pend[c] = 1'b0;
                    if (pend[c] && n == pend_edge[c] + LC) begin
                        nxt_long = 1'b1;
                        pend[c] = 1'b0;
                    end
                    if (m_press[c]) begin
                        pend[c] = 1'b1;
                        pend_edge[c] = n - 1;
                    end
                end

                if (m_long[c]) m_mode[c] = 2'd0;
                else if (m_press[c]) begin
                    case (m_mode[c])
                        2'd0: begin m_mode[c] = 2'd1; entry[c] = n; end
                        2'd1: m_mode[c] = 2'd2;
                        default: m_mode[c] = 2'd0;
                    endcase
                end
                if (m_mode[c] == 2'd2) m_led[c] = 1'b1;
                else if (m_mode[c] == 2'd1) m_led[c] = (((n - entry[c]) / HP) % 2) == 0;
                else m_led[c] = 1'b0;

                m_press[c] = m_fell[c];
                m_fell[c]  = all_diff && m_stable[c];
                if (all_diff) m_stable[c] = ~m_stable[c];
                m_long[c]  = nxt_long;
            end
        end
    end

    logic [CH-1:0]   exp_led, exp_press, exp_long;
    logic [2*CH-1:0] exp_mode;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                exp_led[c] = m_led[c];
                exp_press[c] = m_press[c];
                exp_long[c] = m_long[c];
                exp_mode[2*c +: 2] = m_mode[c];
            end
            check("model_led", 32'(led), 32'(exp_led));
            check("model_mode", 32'(mode), 32'(exp_mode));
            check("model_press", 32'(press_pulse), 32'(exp_press));
            check("model_long", 32'(long_pulse), 32'(exp_long));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        goto(3);
        check("reset_led", 32'(led), 32'd0);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_press", 32'(press_pulse), 32'd0);
        check("reset_long", 32'(long_pulse), 32'd0);
        rst_n = 1'b1;

        // clean press on channel 0, sampled at edge 10
        goto(9);  key_n[0] = 1'b0;
        goto(15); check("press_early", 32'(press_pulse), 32'd0);
        goto(16); check("press_at_16", 32'(press_pulse), 32'b01);
                  check("mode_before_17", 32'(mode), 32'd0);
        goto(17); check("press_gone_17", 32'(press_pulse), 32'd0);
                  check("mode_blink_17", 32'(mode), 32'b0001);
                  check("led_on_17", 32'(led), 32'b01);
                  key_n[0] = 1'b1;

        // blink half-periods: lit 17..24, dark 25..32, lit from 33
        goto(24); check("blink_hi_end", 32'(led[0]), 32'd1);
        goto(25); check("blink_lo_start", 32'(led[0]), 32'd0);
        goto(32); check("blink_lo_end", 32'(led[0]), 32'd0);
        goto(33); check("blink_hi_again", 32'(led[0]), 32'd1);

        // bounce on channel 1: low 3, high 2, low 3, then high
        goto(39); key_n[1] = 1'b0;
        goto(42); key_n[1] = 1'b1;
        goto(44); key_n[1] = 1'b0;
        goto(47); key_n[1] = 1'b1;
        goto(60); check("bounce_mode1", 32'(mode[3:2]), 32'd0);

        // two more presses on channel 0: BLINK -> ON -> OFF
        goto(69); key_n[0] = 1'b0;
        goto(74); key_n[0] = 1'b1;
        goto(77); check("ch0_on_mode", 32'(mode[1:0]), 32'd2);
                  check("ch0_on_led", 32'(led[0]), 32'd1);
        goto(89); key_n[0] = 1'b0;
        goto(94); key_n[0] = 1'b1;
        goto(97); check("ch0_off_mode", 32'(mode[1:0]), 32'd0);
                  check("ch0_off_led", 32'(led[0]), 32'd0);

        // simultaneous press on both channels
        goto(109); key_n = 2'b00;
        goto(116); check("both_press", 32'(press_pulse), 32'b11);
        goto(117); check("both_blink", 32'(mode), 32'b0101);
                   check("both_led", 32'(led), 32'b11);
        goto(118); key_n = 2'b11;

        // asynchronous reset mid-blink
        goto(121);
        #3 rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 32'd0);
        check("async_mode", 32'(mode), 32'd0);
        check("async_press", 32'(press_pulse), 32'd0);
        check("async_long", 32'(long_pulse), 32'd0);

        // first press after reset needs the full debounce interval
        goto(124); rst_n = 1'b1; key_n[1] = 1'b0;
        goto(130); check("post_rst_early", 32'(press_pulse), 32'd0);
        goto(131); check("post_rst_press", 32'(press_pulse), 32'b10);
        goto(132); check("post_rst_mode", 32'(mode), 32'b0100);
        goto(134); key_n[1] = 1'b1;

        // 40-cycle hold on channel 0
        goto(159); key_n[0] = 1'b0;
        goto(166); check("hold_press", 32'(press_pulse), 32'b01);
`ifdef LED_CTRL_LONGPRESS_EN
        goto(197); check("long_early", 32'(long_pulse), 32'd0);
        goto(198); check("long_fire", 32'(long_pulse), 32'b01);
        goto(199); check("long_once", 32'(long_pulse), 32'd0);
                   check("long_mode_off", 32'(mode[1:0]), 32'd0);
                   check("long_led_off", 32'(led[0]), 32'd0);
`else
        goto(198); check("no_long", 32'(long_pulse), 32'd0);
        goto(199); check("hold_blink", 32'(mode[1:0]), 32'd1);
`endif
        key_n[0] = 1'b1;

        goto(240);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000 time units");
        $fatal(1);
    end

endmodule
